vectrex_cart_loader: RTL and testbench
======================================

// Module: vectrex_cart_loader
// PURPOSE
// - Parametrised successor of the core's inline cart-download and reset glue. Sits between hps_io ioctl and vectrex cart port.
// - Routes downloads into NUM_SLOTS slots selected by ioctl_index. Tracks a per-slot power-of-2 address mask.
// - Buffers writes through a 1-entry skid stage with ioctl_wait backpressure. Generates the stretched core reset.
// PARAMETERS
// - ADDR_W    15        cart address bits per slot; mask width
// - IOCTL_AW  25        ioctl_addr width
// - DATA_W    8         ioctl/cart data width
// - NUM_SLOTS 2         slot count; slot = ioctl_index % NUM_SLOTS
// - RST_HOLD  12000000  clk_sys cycles that core_reset stays high after the last request
// PORTS
// - clk_sys         in   1                    system clock; all logic on posedge
// - reset_n         in   1                    asynchronous, active-low reset
// - ioctl_download  in   1                    download in progress
// - ioctl_wr        in   1                    write strobe, 1 cycle
// - ioctl_addr      in   IOCTL_AW             byte address within file
// - ioctl_dout      in   DATA_W               byte data
// - ioctl_index     in   8                    file index from menu
// - ioctl_wait      out  1                    backpressure to hps_io
// - reset_req       in   1                    OR of RESET/menu/button requests (level)
// - cart_busy       in   1                    downstream cannot accept a write this cycle
// - cart_wr         out  1                    write strobe to cart RAM
// - cart_addr       out  ADDR_W               write address (ioctl_addr[ADDR_W-1:0])
// - cart_data       out  DATA_W               write data
// - cart_slot       out  $clog2(NUM_SLOTS)>0  slot of current write
// - cart_mask       out  NUM_SLOTS*ADDR_W     per-slot mask; slot s at [s*ADDR_W +: ADDR_W]
// - overflow        out  1                    sticky: write addressed at or beyond 2**ADDR_W
// - load_done       out  1                    1-cycle pulse at end of download
// - core_reset      out  1                    active-high reset to vectrex core
// BEHAVIOUR
// - Reset values (reset_n=0):
//   - all masks 0
//   - cart_wr, ioctl_wait, overflow, load_done = 0
//   - core_reset = 1; hold counter = 0
//   - FSM in IDLE
// - FSM IDLE -> LOAD on rising edge of ioctl_download (edge-detect register).
//   - On entry: latch slot, clear that slot's mask only, clear overflow.
//   - Other slots keep their masks.
// - LOAD -> DRAIN when ioctl_download falls.
// - DRAIN -> IDLE once the skid buffer is empty and cart_wr is not pending.
//   - load_done pulses on that same transition cycle.
// - Mask update on each accepted write in LOAD:
//   - mask[slot] <= mask[slot] | smear(addr), where smear sets every bit at or below the MSB of addr[ADDR_W-1:0].
//   - Result is the mask for the smallest power-of-2 size covering addr, in one cycle. addr 0 leaves the mask unchanged.
//   - Writes with ioctl_addr[IOCTL_AW-1:ADDR_W] != 0: set overflow, no mask update, no cart_wr.
// - Write path:
//   - An accepted ioctl_wr registers to cart_wr/addr/data/slot on the next cycle (latency 1).
//   - If cart_busy is high while cart_wr is pending: hold outputs, and capture any new ioctl write into the skid entry.
//   - ioctl_wait = skid entry full. No write is ever dropped or duplicated.
//   - cart_wr deasserts on the cycle after acceptance (~cart_busy), unless the skid entry refills it.
// - ioctl_wr while not in LOAD (IDLE/DRAIN): ignored.
// - ioctl_wr coinciding with the rising download edge: accepted, against the freshly cleared mask.
// - Reset stretch:
//   - Hold counter clears whenever reset_req | ioctl_download.
//   - Otherwise it increments, saturating at RST_HOLD.
//   - core_reset = (counter < RST_HOLD), registered.
//   - core_reset is therefore high throughout a download and for RST_HOLD cycles after it.
// - reset_n assertion mid-download: all state returns to reset values immediately; the partial load is discarded.
//   - After release, a still-high ioctl_download does NOT re-enter LOAD; a new rising edge is required.
// STRUCTURE
// - vectrex_pkg: slot_t typedef, loader_state_e {IDLE,LOAD,DRAIN}, RST_HOLD_DEFAULT constant.
// - Sub-module vectrex_skid_buf (1-entry, DATA_W+ADDR_W+slot bits, valid/ready).
// - Mask smear is a function in the package.
// TESTING
// - Test 1 (size): index 0, write bytes at addresses 0..4095 -> cart_mask slot0 = 15'h0FFF, load_done pulses once, overflow = 0.
// - Test 2 (smear): single write at addr 0x1234 -> mask = 15'h1FFF after 1 cycle. Slot1 mask is unchanged from its prior value 15'h07FF.
// - Test 3 (backpressure): cart_busy high 3 cycles during burst of 4 writes -> ioctl_wait asserts.
//   - All 4 cart writes appear in order, exactly once, with correct addr/data.
// - Test 4 (overflow): write at 0x8000 with ADDR_W=15 -> overflow = 1, no cart_wr, mask unchanged. Cleared by next download start.
// - Test 5 (reset stretch): RST_HOLD=100; pulse reset_req 1 cycle -> core_reset high exactly 100+1 cycles after the pulse.
//   - With download high: core_reset stays high throughout.
// - Test 6 (async reset): drop reset_n mid-load with ioctl_download held high -> outputs at reset values asynchronously.
//   - No LOAD re-entry until ioctl_download toggles.

Source files
------------

// File: rtl/vectrex_pkg.sv
// Shared types and helpers for the vectrex cart download path.
package vectrex_pkg;

    localparam int unsigned RST_HOLD_DEFAULT = 12_000_000;
    localparam int unsigned SMEAR_W          = 32;

    typedef logic [7:0] slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } loader_state_e;

    // Sets every bit at or below the MSB of a: smallest power-of-2 mask covering a.
    function automatic logic [SMEAR_W-1:0] smear(input logic [SMEAR_W-1:0] a);
        logic [SMEAR_W-1:0] r;
        r[SMEAR_W-1] = a[SMEAR_W-1];
        for (int i = SMEAR_W - 2; i >= 0; i--) begin
            r[i] = r[i+1] | a[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vectrex_skid_buf.sv
// One-entry holding register with valid/ready handshake on both sides.
module vectrex_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         s_valid,
    output logic         s_ready_c,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    input  logic         m_ready
);

    logic         full_q;
    logic [W-1:0] data_q;

    assign s_ready_c = ~full_q | m_ready;
    assign m_valid   = full_q;
    assign m_data    = data_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (s_valid && s_ready_c) begin
            full_q <= 1'b1;
            data_q <= s_data;
        end else if (m_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/vectrex_cart_loader.sv
// Routes hps_io downloads into cart slots, tracks per-slot size masks,
// and stretches the core reset around requests and downloads.
module vectrex_cart_loader
    import vectrex_pkg::*;
#(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned IOCTL_AW  = 25,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned RST_HOLD  = RST_HOLD_DEFAULT,
    localparam int unsigned SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        ioctl_download,
    input  logic                        ioctl_wr,
    input  logic [IOCTL_AW-1:0]         ioctl_addr,
    input  logic [DATA_W-1:0]           ioctl_dout,
    input  logic [7:0]                  ioctl_index,
    output logic                        ioctl_wait,
    input  logic                        reset_req,
    input  logic                        cart_busy,
    output logic                        cart_wr,
    output logic [ADDR_W-1:0]           cart_addr,
    output logic [DATA_W-1:0]           cart_data,
    output logic [SLOT_W-1:0]           cart_slot,
    output logic [NUM_SLOTS*ADDR_W-1:0] cart_mask,
    output logic                        overflow,
    output logic                        load_done,
    output logic                        core_reset
);

    localparam int unsigned ENT_W = SLOT_W + ADDR_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(RST_HOLD + 1);

    loader_state_e     state_q, state_d;
    logic              done_d;
    logic              dl_q;
    logic              dl_rise_c, entry_c, accept_en_c, in_range_c;
    logic              w_valid_c, w_ovf_c;
    slot_t             idx_mod_c;
    logic [SLOT_W-1:0] new_slot_c, slot_q, cur_slot_c;
    logic [ADDR_W-1:0] smear_c;
    logic [ADDR_W-1:0] mask_q [NUM_SLOTS];
    logic              out_adv_c, direct_c, skid_push_c, skid_ready_c, skid_full;
    logic [ENT_W-1:0]  w_ent_c, skid_ent;
    logic [CNT_W-1:0]  cnt_q;

    assign dl_rise_c   = ioctl_download & ~dl_q;
    assign entry_c     = (state_q == IDLE) & dl_rise_c;
    assign accept_en_c = (state_q == LOAD) | entry_c;
    assign in_range_c  = (ioctl_addr[IOCTL_AW-1:ADDR_W] == '0);
    assign w_valid_c   = accept_en_c & ioctl_wr & in_range_c;
    assign w_ovf_c     = accept_en_c & ioctl_wr & ~in_range_c;
    assign idx_mod_c   = ioctl_index % slot_t'(NUM_SLOTS);
    assign new_slot_c  = SLOT_W'(idx_mod_c);
    assign cur_slot_c  = entry_c ? new_slot_c : slot_q;
    assign smear_c     = ADDR_W'(smear(SMEAR_W'(ioctl_addr[ADDR_W-1:0])));
    assign w_ent_c     = {cur_slot_c, ioctl_addr[ADDR_W-1:0], ioctl_dout};

    // Output stage advances when empty or when the cart takes the pending write.
    assign out_adv_c   = ~cart_wr | ~cart_busy;
    assign direct_c    = w_valid_c & out_adv_c & ~skid_full;
    assign skid_push_c = w_valid_c & ~direct_c & skid_ready_c;
    assign ioctl_wait  = skid_full;

    vectrex_skid_buf #(.W(ENT_W)) u_skid (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .s_valid   (skid_push_c),
        .s_ready_c (skid_ready_c),
        .s_data    (w_ent_c),
        .m_valid   (skid_full),
        .m_data    (skid_ent),
        .m_ready   (out_adv_c)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (dl_rise_c) state_d = LOAD;
            LOAD:    if (!ioctl_download) state_d = DRAIN;
            DRAIN: begin
                if (!skid_full && !cart_wr) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge detector resets high so a download held across reset is not re-entered.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            dl_q      <= 1'b1;
            load_done <= 1'b0;
            slot_q    <= '0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_q      <= ioctl_download;
            load_done <= done_d;
            if (entry_c) begin
                slot_q   <= new_slot_c;
                overflow <= w_ovf_c;
            end else if (w_ovf_c) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) mask_q[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (SLOT_W'(s) == cur_slot_c) begin
                    if (entry_c)        mask_q[s] <= w_valid_c ? smear_c : '0;
                    else if (w_valid_c) mask_q[s] <= mask_q[s] | smear_c;
                end
            end
        end
    end

    always_comb begin
        cart_mask = '0;
        for (int s = 0; s < NUM_SLOTS; s++) cart_mask[s*ADDR_W +: ADDR_W] = mask_q[s];
    end

    // Skid content is older than any concurrent ioctl write, so it goes out first.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cart_wr   <= 1'b0;
            cart_slot <= '0;
            cart_addr <= '0;
            cart_data <= '0;
        end else if (out_adv_c) begin
            if (skid_full) begin
                cart_wr                           <= 1'b1;
                {cart_slot, cart_addr, cart_data} <= skid_ent;
            end else if (direct_c) begin
                cart_wr                           <= 1'b1;
                {cart_slot, cart_addr, cart_data} <= w_ent_c;
            end else begin
                cart_wr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            core_reset <= 1'b1;
        end else begin
            if (reset_req || ioctl_download)   cnt_q <= '0;
            else if (cnt_q != CNT_W'(RST_HOLD)) cnt_q <= cnt_q + CNT_W'(1);
            core_reset <= (cnt_q < CNT_W'(RST_HOLD));
        end
    end

endmodule

// File: tb/tb_vectrex_cart_loader.sv
// Scoreboard bench for vectrex_cart_loader: slot masks, skid backpressure,
// overflow, reset stretch and asynchronous reset behaviour.
module tb_vectrex_cart_loader;

    typedef struct packed {
        logic [0:0]  slot;
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download, ioctl_wr, ioctl_wait;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic        reset_req, cart_busy, cart_wr;
    logic [14:0] cart_addr;
    logic [7:0]  cart_data;
    logic [0:0]  cart_slot;
    logic [29:0] cart_mask;
    logic        overflow, load_done, core_reset;

    int  tests = 0;
    int  fails = 0;
    int  ld_seen = 0;
    int  cart_acc = 0;
    logic [0:0] tb_slot = 1'b0;
    wr_t exp_q[$];

    always #5 clk_sys = ~clk_sys;

    vectrex_cart_loader #(
        .ADDR_W(15), .IOCTL_AW(25), .DATA_W(8), .NUM_SLOTS(2), .RST_HOLD(100)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
        .reset_req(reset_req), .cart_busy(cart_busy), .cart_wr(cart_wr),
        .cart_addr(cart_addr), .cart_data(cart_data), .cart_slot(cart_slot),
        .cart_mask(cart_mask), .overflow(overflow), .load_done(load_done),
        .core_reset(core_reset)
    );

    function automatic logic [14:0] mask0();
        return cart_mask[14:0];
    endfunction

    function automatic logic [14:0] mask1();
        return cart_mask[29:15];
    endfunction

    // One clock: mid-cycle scoreboard pop on each cart write accepted, then step past the edge.
    task automatic tick();
        wr_t e;
        @(negedge clk_sys);
        if (cart_wr && !cart_busy) begin
            cart_acc++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL cart_wr_unexpected: got slot=%0d addr=%h data=%h, required no write",
                         cart_slot, cart_addr, cart_data);
            end else begin
                e = exp_q.pop_front();
                if ({cart_slot, cart_addr, cart_data} !== e) begin
                    fails++;
                    $display("FAIL cart_wr_data: got slot=%0d addr=%h data=%h, required slot=%0d addr=%h data=%h",
                             cart_slot, cart_addr, cart_data, e.slot, e.addr, e.data);
                end
            end
        end
        if (load_done) ld_seen++;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ioctl_write(input logic [24:0] a, input logic [7:0] d, input bit acc);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (acc) exp_q.push_back({tb_slot, a[14:0], d});
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tb_slot        = idx[0];
        tick();
    endtask

    task automatic end_download();
        int start = ld_seen;
        int n = 0;
        ioctl_download = 1'b0;
        while (ld_seen == start && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (ld_seen == start) begin
            fails++;
            $display("FAIL load_done_timeout: got no pulse in %0d cycles, required one", n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_index = '0; reset_req = 1'b0; cart_busy = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        tests++;
        if ({cart_wr, ioctl_wait, overflow, load_done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes: got wr/wait/ovf/done=%b, required 0000",
                     {cart_wr, ioctl_wait, overflow, load_done});
        end
        tests++;
        if (core_reset !== 1'b1) begin
            fails++;
            $display("FAIL reset_core_reset: got %b, required 1", core_reset);
        end
        tests++;
        if (cart_mask !== 30'h0) begin
            fails++;
            $display("FAIL reset_mask: got %h, required 0", cart_mask);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_size();
        int cr_bad = 0;
        ld_seen  = 0;
        cart_acc = 0;
        start_download(8'd0);
        for (int a = 0; a < 4096; a++) begin
            ioctl_write(25'(a), 8'(a) ^ 8'h5A, 1'b1);
            if (core_reset !== 1'b1) cr_bad++;
        end
        end_download();
        repeat (5) tick();
        tests++;
        if (mask0() !== 15'h0FFF) begin
            fails++;
            $display("FAIL size_mask0: got %h, required 0fff", mask0());
        end
        tests++;
        if (ld_seen !== 1) begin
            fails++;
            $display("FAIL size_load_done_count: got %0d, required 1", ld_seen);
        end
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL size_overflow: got %b, required 0", overflow);
        end
        tests++;
        if (cart_acc !== 4096 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL size_write_count: got %0d writes, %0d pending, required 4096, 0",
                     cart_acc, exp_q.size());
        end
        tests++;
        if (cr_bad !== 0) begin
            fails++;
            $display("FAIL size_core_reset_hold: got %0d low cycles, required 0", cr_bad);
        end
    endtask

    task automatic test_smear();
        // Slot 1 download whose first write coincides with the rising edge.
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tb_slot        = 1'b1;
        ioctl_write(25'h07FF, 8'hA7, 1'b1);
        tests++;
        if (mask1() !== 15'h07FF || mask0() !== 15'h0FFF) begin
            fails++;
            $display("FAIL smear_edge_write: got m1=%h m0=%h, required m1=07ff m0=0fff", mask1(), mask0());
        end
        end_download();
        start_download(8'd2);
        tests++;
        if (mask0() !== 15'h0 || mask1() !== 15'h07FF) begin
            fails++;
            $display("FAIL smear_entry_clear: got m0=%h m1=%h, required m0=0000 m1=07ff", mask0(), mask1());
        end
        ioctl_write(25'h0, 8'h01, 1'b1);
        tests++;
        if (mask0() !== 15'h0) begin
            fails++;
            $display("FAIL smear_addr0: got %h, required 0000", mask0());
        end
        ioctl_write(25'h1234, 8'h3C, 1'b1);
        tests++;
        if (mask0() !== 15'h1FFF || mask1() !== 15'h07FF) begin
            fails++;
            $display("FAIL smear_1234: got m0=%h m1=%h, required m0=1fff m1=07ff", mask0(), mask1());
        end
        end_download();
    endtask

    task automatic test_backpressure();
        int i = 0;
        int cyc = 0;
        int acc0;
        bit wait_seen = 1'b0;
        start_download(8'd0);
        acc0 = cart_acc;
        while (i < 4 && cyc < 50) begin
            cart_busy = (cyc >= 1 && cyc <= 3);
            if (!ioctl_wait) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'h0300 + 25'(i);
                ioctl_dout = 8'hC0 + 8'(i);
                exp_q.push_back({tb_slot, ioctl_addr[14:0], ioctl_dout});
                i++;
            end else begin
                wait_seen = 1'b1;
            end
            tick();
            ioctl_wr = 1'b0;
            cyc++;
        end
        cart_busy = 1'b0;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        tick();
        tests++;
        if (wait_seen !== 1'b1) begin
            fails++;
            $display("FAIL bp_wait_asserted: got %b, required 1", wait_seen);
        end
        tests++;
        if (cart_acc - acc0 !== 4 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL bp_write_count: got %0d writes, %0d pending, required 4, 0",
                     cart_acc - acc0, exp_q.size());
        end
        end_download();
    endtask

    task automatic test_overflow();
        logic [14:0] m;
        start_download(8'd0);
        ioctl_write(25'h0020, 8'h55, 1'b1);
        m = mask0();
        ioctl_write(25'h8000, 8'hEE, 1'b0);
        tests++;
        if (overflow !== 1'b1 || cart_wr !== 1'b0 || mask0() !== m) begin
            fails++;
            $display("FAIL ovf_write: got ovf=%b wr=%b mask=%h, required ovf=1 wr=0 mask=%h",
                     overflow, cart_wr, mask0(), m);
        end
        end_download();
        tests++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got %b, required 1", overflow);
        end
        ioctl_write(25'h0040, 8'h11, 1'b0);
        repeat (3) tick();
        tests++;
        if (mask0() !== 15'h003F) begin
            fails++;
            $display("FAIL idle_write_ignored: got mask=%h, required 003f", mask0());
        end
        start_download(8'd0);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear_on_start: got %b, required 0", overflow);
        end
        end_download();
    endtask

    task automatic test_reset_stretch();
        int bad = 0;
        repeat (110) tick();
        tests++;
        if (core_reset !== 1'b0) begin
            fails++;
            $display("FAIL stretch_idle: got %b, required 0", core_reset);
        end
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        for (int k = 1; k <= 104; k++) begin
            if (k >= 2 && core_reset !== ((k <= 101) ? 1'b1 : 1'b0)) begin
                if (bad == 0)
                    $display("FAIL stretch_cycle: got %b at cycle %0d, required %b",
                             core_reset, k, (k <= 101));
                bad++;
            end
            tick();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stretch_window: got %0d wrong cycles, required 0", bad);
        end
    endtask

    task automatic test_async_reset();
        int ld0;
        start_download(8'd0);
        cart_busy = 1'b1;
        ioctl_write(25'h0010, 8'h10, 1'b1);
        ioctl_write(25'h0011, 8'h11, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({cart_wr, ioctl_wait, overflow, load_done, core_reset} !== 5'b00001 || cart_mask !== 30'h0) begin
            fails++;
            $display("FAIL async_reset_values: got wr/wait/ovf/done/crst=%b mask=%h, required 00001 mask=0",
                     {cart_wr, ioctl_wait, overflow, load_done, core_reset}, cart_mask);
        end
        exp_q.delete();
        cart_busy = 1'b0;
        @(posedge clk_sys);
        #1 reset_n = 1'b1;
        repeat (5) tick();
        ioctl_write(25'h0100, 8'h77, 1'b0);
        repeat (3) tick();
        tests++;
        if (cart_mask !== 30'h0) begin
            fails++;
            $display("FAIL async_no_reentry: got mask=%h, required 0", cart_mask);
        end
        ld0 = ld_seen;
        ioctl_download = 1'b0;
        repeat (3) tick();
        tests++;
        if (ld_seen !== ld0) begin
            fails++;
            $display("FAIL async_no_done: got %0d pulses, required 0", ld_seen - ld0);
        end
        start_download(8'd0);
        ioctl_write(25'h0100, 8'h77, 1'b1);
        tests++;
        if (mask0() !== 15'h01FF) begin
            fails++;
            $display("FAIL async_reload_mask: got %h, required 01ff", mask0());
        end
        end_download();
        repeat (3) tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL async_pending: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_size();
        test_smear();
        test_backpressure();
        test_overflow();
        test_reset_stretch();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "watchdog");
    end

endmodule
